// File: rtl/decode_queue.sv
// Decode queue: circular instruction buffer between fetch and the two decoders.
// One enqueue per cycle, up to two in-order retirements per cycle, flush clears everything.
module decode_queue #(
    parameter int unsigned LG_DQ_ENTRIES = 3,
    parameter int unsigned M_WIDTH       = 32,
    parameter int unsigned LG_PHT_SZ     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     fq_valid,
    output logic                     fq_ready,
    input  logic [31:0]              fq_insn,
    input  logic [M_WIDTH-1:0]       fq_pc,
    input  logic                     fq_pred,
    input  logic [LG_PHT_SZ-1:0]     fq_pht_idx,
    input  logic [M_WIDTH-1:0]       fq_pred_target,

    output logic                     dq0_valid,
    output logic                     dq1_valid,
    output logic [31:0]              dq0_insn,
    output logic [31:0]              dq1_insn,
    output logic [M_WIDTH-1:0]       dq0_pc,
    output logic [M_WIDTH-1:0]       dq1_pc,
    output logic                     dq0_pred,
    output logic                     dq1_pred,
    output logic [LG_PHT_SZ-1:0]     dq0_pht_idx,
    output logic [LG_PHT_SZ-1:0]     dq1_pht_idx,
    output logic [M_WIDTH-1:0]       dq0_pred_target,
    output logic [M_WIDTH-1:0]       dq1_pred_target,
    input  logic                     dq_pop0,
    input  logic                     dq_pop1,

    output logic [LG_DQ_ENTRIES:0]   dq_occupancy
);

    localparam int unsigned DEPTH = 1 << LG_DQ_ENTRIES;
    localparam int unsigned PW    = LG_DQ_ENTRIES + 1;
    localparam int unsigned IW    = LG_DQ_ENTRIES;

    typedef struct packed {
        logic [31:0]          insn;
        logic [M_WIDTH-1:0]   pc;
        logic                 pred;
        logic [LG_PHT_SZ-1:0] pht_idx;
        logic [M_WIDTH-1:0]   pred_target;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          rd0_entry;
    entry_t          rd1_entry;

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head_nxt;
    logic [PW-1:0]   tail_nxt;
    logic [PW-1:0]   count_nxt;
    logic            full_nxt;
    logic            enq;
    logic            take0;
    logic            take1;
    logic [1:0]      pop_cnt;
    logic [IW-1:0]   head_idx;
    logic [IW-1:0]   head1_idx;

    // Handshake and retire counts; a pop of an empty slot or pop1 alone retires nothing.
    always_comb begin
        enq     = fq_valid & fq_ready & ~flush;
        take0   = dq_pop0 & dq0_valid;
        take1   = dq_pop0 & dq_pop1 & dq1_valid;
        pop_cnt = 2'(take0) + 2'(take1);
    end

    // Next pointers; flush wins over any same-cycle enqueue or pop.
    always_comb begin
        head_nxt = head + PW'(pop_cnt);
        tail_nxt = tail + PW'(enq);
        if (flush) begin
            head_nxt = '0;
            tail_nxt = '0;
        end
        count_nxt = tail_nxt - head_nxt;
        full_nxt  = (tail_nxt[IW-1:0] == head_nxt[IW-1:0]) &&
                    (tail_nxt[IW] != head_nxt[IW]);
    end

    // Pointers plus status flags, all registered from the post-update pointer values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            dq_occupancy <= '0;
            dq0_valid    <= 1'b0;
            dq1_valid    <= 1'b0;
            fq_ready     <= 1'b1;
        end else begin
            head         <= head_nxt;
            tail         <= tail_nxt;
            dq_occupancy <= count_nxt;
            dq0_valid    <= (count_nxt != '0);
            dq1_valid    <= (count_nxt >= PW'(2));
            fq_ready     <= ~full_nxt;
        end
    end

    always_comb begin
        wr_entry.insn        = fq_insn;
        wr_entry.pc          = fq_pc;
        wr_entry.pred        = fq_pred;
        wr_entry.pht_idx     = fq_pht_idx;
        wr_entry.pred_target = fq_pred_target;
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail[IW-1:0]] <= wr_entry;
        end
    end

    // Read ports only see registered storage and pointers, so fetch never reaches decode combinationally.
    always_comb begin
        head_idx  = head[IW-1:0];
        head1_idx = head_idx + IW'(1);
        rd0_entry = mem[head_idx];
        rd1_entry = mem[head1_idx];
    end

    assign dq0_insn        = rd0_entry.insn;
    assign dq0_pc          = rd0_entry.pc;
    assign dq0_pred        = rd0_entry.pred;
    assign dq0_pht_idx     = rd0_entry.pht_idx;
    assign dq0_pred_target = rd0_entry.pred_target;

    assign dq1_insn        = rd1_entry.insn;
    assign dq1_pc          = rd1_entry.pc;
    assign dq1_pred        = rd1_entry.pred;
    assign dq1_pht_idx     = rd1_entry.pht_idx;
    assign dq1_pred_target = rd1_entry.pred_target;

`ifndef SYNTHESIS
    // Retiring slot 1 without slot 0 would break in-order decode.
    pop1_needs_pop0 : assert property (@(posedge clk) disable iff (!reset)
        !(dq_pop1 && !dq_pop0));
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_decode_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        fq_valid;
    logic        fq_ready;
    logic [31:0] fq_insn;
    logic [31:0] fq_pc;
    logic        fq_pred;
    logic [15:0] fq_pht_idx;
    logic [31:0] fq_pred_target;
    logic        dq0_valid, dq1_valid;
    logic [31:0] dq0_insn, dq1_insn;
    logic [31:0] dq0_pc, dq1_pc;
    logic        dq0_pred, dq1_pred;
    logic [15:0] dq0_pht_idx, dq1_pht_idx;
    logic [31:0] dq0_pred_target, dq1_pred_target;
    logic        dq_pop0, dq_pop1;
    logic [3:0]  dq_occupancy;

    int checks = 0;
    int errors = 0;

    decode_queue #(.LG_DQ_ENTRIES(3), .M_WIDTH(32), .LG_PHT_SZ(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_insn(fq_insn), .fq_pc(fq_pc),
        .fq_pred(fq_pred), .fq_pht_idx(fq_pht_idx), .fq_pred_target(fq_pred_target),
        .dq0_valid(dq0_valid), .dq1_valid(dq1_valid),
        .dq0_insn(dq0_insn), .dq1_insn(dq1_insn),
        .dq0_pc(dq0_pc), .dq1_pc(dq1_pc),
        .dq0_pred(dq0_pred), .dq1_pred(dq1_pred),
        .dq0_pht_idx(dq0_pht_idx), .dq1_pht_idx(dq1_pht_idx),
        .dq0_pred_target(dq0_pred_target), .dq1_pred_target(dq1_pred_target),
        .dq_pop0(dq_pop0), .dq_pop1(dq_pop1),
        .dq_occupancy(dq_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain FIFO of entries, oldest at index 0, capacity 8.
    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        pred;
        logic [15:0] pht;
        logic [31:0] tgt;
    } ent_t;

    ent_t mq[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            int  n;
            bit  room;
            ent_t e;
            room = (mq.size() < 8);
            n = 0;
            if (dq_pop0 && mq.size() >= 1) n = 1;
            if (dq_pop0 && dq_pop1 && mq.size() >= 2) n = 2;
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (fq_valid && room) begin
                e.insn = fq_insn; e.pc = fq_pc; e.pred = fq_pred;
                e.pht = fq_pht_idx; e.tgt = fq_pred_target;
                mq.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_occ", 64'(dq_occupancy), 64'(mq.size()));
        check("m_ready", 64'(fq_ready), 64'(mq.size() < 8));
        check("m_v0", 64'(dq0_valid), 64'(mq.size() >= 1));
        check("m_v1", 64'(dq1_valid), 64'(mq.size() >= 2));
        if (mq.size() >= 1) begin
            check("m_insn0", 64'(dq0_insn), 64'(mq[0].insn));
            check("m_pc0", 64'(dq0_pc), 64'(mq[0].pc));
            check("m_pred0", 64'(dq0_pred), 64'(mq[0].pred));
            check("m_pht0", 64'(dq0_pht_idx), 64'(mq[0].pht));
            check("m_tgt0", 64'(dq0_pred_target), 64'(mq[0].tgt));
        end
        if (mq.size() >= 2) begin
            check("m_insn1", 64'(dq1_insn), 64'(mq[1].insn));
            check("m_pc1", 64'(dq1_pc), 64'(mq[1].pc));
            check("m_pred1", 64'(dq1_pred), 64'(mq[1].pred));
            check("m_pht1", 64'(dq1_pht_idx), 64'(mq[1].pht));
            check("m_tgt1", 64'(dq1_pred_target), 64'(mq[1].tgt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fq(input logic [31:0] pc, input logic [31:0] insn, input logic pred,
                          input logic [15:0] pht, input logic [31:0] tgt);
        fq_valid = 1'b1;
        fq_pc = pc; fq_insn = insn; fq_pred = pred;
        fq_pht_idx = pht; fq_pred_target = tgt;
    endtask

    int          occ_exp [10] = '{6, 5, 4, 3, 2, 1, 1, 1, 1, 1};
    logic [31:0] popped[$];
    logic [31:0] pcn;
    logic [31:0] exp_pc;
    bit          acc;

    initial begin
        reset = 1'b1; flush = 1'b0; fq_valid = 1'b0; fq_insn = '0; fq_pc = '0;
        fq_pred = 1'b0; fq_pht_idx = '0; fq_pred_target = '0;
        dq_pop0 = 1'b0; dq_pop1 = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_v0", 64'(dq0_valid), 64'd0);
        check("rst_v1", 64'(dq1_valid), 64'd0);
        check("rst_occ", 64'(dq_occupancy), 64'd0);
        check("rst_ready", 64'(fq_ready), 64'd1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            set_fq(32'h0100 + 32'(4 * i), 32'h13 + 32'(i << 7), 1'b0, 16'(i), 32'h0);
            tick();
        end
        fq_valid = 1'b0;
        check("mid_occ5", 64'(dq_occupancy), 64'd5);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_v0", 64'(dq0_valid), 64'd0);
        check("mid_v1", 64'(dq1_valid), 64'd0);
        check("mid_occ", 64'(dq_occupancy), 64'd0);
        check("mid_ready", 64'(fq_ready), 64'd1);
        #2 reset = 1'b1;
        tick();

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            set_fq(32'h1000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7), i[0], 16'(16'h100 + i),
                   32'h8000 + 32'(i));
            tick();
        end
        check("full_ready", 64'(fq_ready), 64'd0);
        check("full_occ", 64'(dq_occupancy), 64'd8);
        check("full_pc0", 64'(dq0_pc), 64'h1000);
        check("full_pc1", 64'(dq1_pc), 64'h1004);
        pcn = 32'h2000;
        set_fq(pcn, 32'h0000_0033, 1'b0, 16'h0, 32'h0);
        tick();
        check("held_occ", 64'(dq_occupancy), 64'd8);
        check("held_pc0", 64'(dq0_pc), 64'h1000);

        // Dual drain across the wrap while fetch keeps offering
        dq_pop0 = 1'b1; dq_pop1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (dq0_valid) popped.push_back(dq0_pc);
            if (dq1_valid) popped.push_back(dq1_pc);
            acc = fq_valid && fq_ready;
            tick();
            if (acc) begin
                pcn = pcn + 32'd4;
                set_fq(pcn, 32'h0000_0033 + (pcn << 12), 1'b0, 16'h0, 32'h0);
            end
            check("drain_occ", 64'(dq_occupancy), 64'(occ_exp[k]));
        end
        fq_valid = 1'b0; dq_pop0 = 1'b0; dq_pop1 = 1'b0;
        check("drain_count", 64'(popped.size()), 64'd16);
        for (int i = 0; i < popped.size() && i < 16; i++) begin
            exp_pc = (i < 8) ? 32'h1000 + 32'(4 * i) : 32'h2000 + 32'(4 * (i - 8));
            check("drain_order", 64'(popped[i]), 64'(exp_pc));
        end
        check("drain_left", 64'(dq0_pc), 64'h2020);
        dq_pop0 = 1'b1;
        tick();
        dq_pop0 = 1'b0;
        check("drain_empty", 64'(dq_occupancy), 64'd0);

        // Single entry with a double pop
        set_fq(32'h3000, 32'h0000_0013, 1'b0, 16'h0, 32'h0);
        tick();
        fq_valid = 1'b0;
        check("one_v0", 64'(dq0_valid), 64'd1);
        check("one_v1", 64'(dq1_valid), 64'd0);
        check("one_occ", 64'(dq_occupancy), 64'd1);
        check("one_insn", 64'(dq0_insn), 64'h13);
        dq_pop0 = 1'b1; dq_pop1 = 1'b1;
        tick();
        dq_pop0 = 1'b0; dq_pop1 = 1'b0;
        check("one_occ0", 64'(dq_occupancy), 64'd0);
        check("one_v1b", 64'(dq1_valid), 64'd0);

        // Flush with concurrent enqueue and pops
        for (int i = 0; i < 6; i++) begin
            set_fq(32'h5000 + 32'(4 * i), 32'h13, 1'b0, 16'h0, 32'h0);
            tick();
        end
        check("fl_occ6", 64'(dq_occupancy), 64'd6);
        set_fq(32'h6000, 32'h6000_0013, 1'b1, 16'h6666, 32'h6000);
        dq_pop0 = 1'b1; dq_pop1 = 1'b1; flush = 1'b1;
        check("fl_ready", 64'(fq_ready), 64'd1);
        tick();
        fq_valid = 1'b0; dq_pop0 = 1'b0; dq_pop1 = 1'b0; flush = 1'b0;
        check("fl_occ", 64'(dq_occupancy), 64'd0);
        check("fl_v0", 64'(dq0_valid), 64'd0);
        check("fl_v1", 64'(dq1_valid), 64'd0);
        tick();
        tick();
        check("fl_stay", 64'(dq_occupancy), 64'd0);

        // Sideband integrity and one-cycle fall-through
        set_fq(32'h7000, 32'h0000_0063, 1'b1, 16'hBEEF, 32'h4000_0000);
        #1;
        check("sb_same_cycle", 64'(dq0_valid), 64'd0);
        tick();
        fq_valid = 1'b0;
        check("sb_v0", 64'(dq0_valid), 64'd1);
        check("sb_pred", 64'(dq0_pred), 64'd1);
        check("sb_pht", 64'(dq0_pht_idx), 64'hBEEF);
        check("sb_tgt", 64'(dq0_pred_target), 64'h4000_0000);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
